// File: rtl/inst_prefetch_queue.sv
// Fetch-side prefetch queue: owns the fetch PC, keeps up to DEPTH words outstanding or buffered.
// Optional same-cycle response bypass when INST_PREFETCH_BYPASS_EN is defined.
module inst_prefetch_queue #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       LENGTH   = 32,
  parameter logic [LENGTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  output logic [LENGTH-1:0] req_addr,
  input  logic              req_ready,
  input  logic              resp_valid,
  input  logic [LENGTH-1:0] resp_data,
  output logic              inst_valid,
  output logic [LENGTH-1:0] inst,
  output logic [LENGTH-1:0] inst_pc,
  output logic [LENGTH-1:0] inst_pc_4,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [LENGTH-1:0] redirect_pc
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [LENGTH-1:0] PC_STEP = LENGTH'(4);

  typedef enum logic {RUN, DRAIN} stateT;
  typedef struct packed {
    logic [LENGTH-1:0] word;
    logic [LENGTH-1:0] pc;
  } entryT;

  stateT             state, stateNext;
  logic [LENGTH-1:0] fetchPc, fetchPcNext;
  logic [LENGTH-1:0] respPc, respPcNext;
  logic [CNT_W-1:0]  count, countNext;
  logic [CNT_W-1:0]  inflight, inflightNext;
  logic [CNT_W-1:0]  discard, discardNext;
  logic [PTR_W-1:0]  headPtr, headPtrNext;
  logic [PTR_W-1:0]  tailPtr, tailPtrNext;
  entryT             entries [DEPTH];
  entryT             headEntry;

  logic [LENGTH-1:0] target;
  logic reqFire, respDrop, respKeep, bypassHit, bypassTake, push, pop;

  assign target    = redirect_pc & ~LENGTH'(3);
  assign req_valid = rst && !redirect &&
                     ((SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH));
  assign req_addr  = fetchPc;
  assign reqFire   = req_valid && req_ready;
  assign respDrop  = resp_valid && (discard != '0);
  assign respKeep  = resp_valid && (discard == '0) && !redirect;

`ifdef INST_PREFETCH_BYPASS_EN
  assign bypassHit = respKeep && (count == '0);
`else
  assign bypassHit = 1'b0;
`endif

  // A bypassed word taken by the pipeline in the same cycle never enters the queue.
  assign bypassTake = bypassHit && inst_ready;
  assign push       = respKeep && !bypassTake;
  assign pop        = (count != '0) && inst_ready && !redirect;

  assign headEntry  = entries[headPtr];
  assign inst_valid = (count != '0) || bypassHit;
  assign inst       = bypassHit ? resp_data : headEntry.word;
  assign inst_pc    = bypassHit ? respPc : headEntry.pc;
  assign inst_pc_4  = inst_pc + PC_STEP;

  // Next-state: redirect overrides every other update in the same cycle.
  always_comb begin
    stateNext    = state;
    fetchPcNext  = fetchPc;
    respPcNext   = respPc;
    countNext    = count;
    inflightNext = inflight;
    discardNext  = discard;
    headPtrNext  = headPtr;
    tailPtrNext  = tailPtr;
    if (redirect) begin
      fetchPcNext  = target;
      respPcNext   = target;
      countNext    = '0;
      headPtrNext  = tailPtr;
      inflightNext = inflight - CNT_W'(resp_valid);
      discardNext  = inflight - CNT_W'(resp_valid);
    end else begin
      if (reqFire)  fetchPcNext = fetchPc + PC_STEP;
      if (respKeep) respPcNext  = respPc + PC_STEP;
      if (respDrop) discardNext = discard - CNT_W'(1);
      if (push)     tailPtrNext = tailPtr + PTR_W'(1);
      if (pop)      headPtrNext = headPtr + PTR_W'(1);
      countNext    = count + CNT_W'(push) - CNT_W'(pop);
      inflightNext = inflight + CNT_W'(reqFire) - CNT_W'(resp_valid);
    end
    case (state)
      RUN:     if (redirect && (discardNext != '0)) stateNext = DRAIN;
      DRAIN:   if (discardNext == '0) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      fetchPc  <= RESET_PC;
      respPc   <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      headPtr  <= '0;
      tailPtr  <= '0;
    end else begin
      state    <= stateNext;
      fetchPc  <= fetchPcNext;
      respPc   <= respPcNext;
      count    <= countNext;
      inflight <= inflightNext;
      discard  <= discardNext;
      headPtr  <= headPtrNext;
      tailPtr  <= tailPtrNext;
    end
  end

  // Entry storage, cleared so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries <= '{default: '0};
    end else if (push) begin
      entries[tailPtr] <= {resp_data, respPc};
    end
  end
endmodule
